// File: rtl/multiplexor_2to1.sv
// Two-input word selector for the 8-bit datapath.
// Combinational output plus an enabled registered copy with its select bit.
module multiplexor_2to1 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic             selector,
  input  logic             en,
  output logic [WIDTH-1:0] output1,
  output logic [WIDTH-1:0] output1_q,
  output logic             sel_q
);

  logic [WIDTH-1:0] output1_d;
  logic             sel_d;

  // Unknown select propagates as all-X rather than a bitwise merge.
  always_comb begin
    output1 = 'x;
    unique case (selector)
      1'b0: output1 = input1;
      1'b1: output1 = input2;
      default: output1 = 'x;
    endcase
  end

  always_comb begin
    output1_d = output1_q;
    sel_d     = sel_q;
    if (en) begin
      output1_d = output1;
      sel_d     = selector;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      output1_q <= '0;
      sel_q     <= 1'b0;
    end else begin
      output1_q <= output1_d;
      sel_q     <= sel_d;
    end
  end

endmodule

// File: tb/tb_multiplexor_2to1.sv
// Self-checking bench for multiplexor_2to1.
// Random and directed stimulus against a behavioural word-select model.
module tb_multiplexor_2to1;

  logic       clk;
  logic       rst_n;
  logic [7:0] input1;
  logic [7:0] input2;
  logic       selector;
  logic       en;
  logic [7:0] output1;
  logic [7:0] output1_q;
  logic       sel_q;

  int total;
  int bad;

  logic [7:0] m_q;
  logic       m_sel;

  multiplexor_2to1 #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .input1   (input1),
    .input2   (input2),
    .selector (selector),
    .en       (en),
    .output1  (output1),
    .output1_q(output1_q),
    .sel_q    (sel_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pick(logic s, logic [7:0] a, logic [7:0] b);
    return s ? b : a;
  endfunction

  // Advance one rising edge, updating the reference register model.
  task automatic cycle();
    @(posedge clk);
    if (rst_n && en) begin
      m_q   = pick(selector, input1, input2);
      m_sel = selector;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    input1 = 8'hAA;
    input2 = 8'h55;
    selector = 1'b1;
    en = 1'b1;
    m_q = 8'h00;
    m_sel = 1'b0;
    #1;
    total++;
    if (output1_q !== 8'h00) begin
      bad++;
      $display("FAIL reset_q got=%h exp=00", output1_q);
    end
    total++;
    if (sel_q !== 1'b0) begin
      bad++;
      $display("FAIL reset_sel got=%b exp=0", sel_q);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (output1_q !== 8'h00 || sel_q !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold q=%h sel=%b exp=00/0", output1_q, sel_q);
      end
      total++;
      if (output1 !== 8'h55) begin
        bad++;
        $display("FAIL reset_comb got=%h exp=55", output1);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_comb();
    logic [7:0] a [4];
    logic [7:0] b [4];
    logic       s [4];
    logic [7:0] e [4];
    a = '{8'd0, 8'd20, 8'd10, 8'h8C};
    b = '{8'd0, 8'd10, 8'd20, 8'h1D};
    s = '{1'b0, 1'b1, 1'b0, 1'b1};
    e = '{8'h00, 8'h0A, 8'h0A, 8'h1D};
    for (int i = 0; i < 4; i++) begin
      input1 = a[i];
      input2 = b[i];
      selector = s[i];
      #1;
      total++;
      if (output1 !== e[i]) begin
        bad++;
        $display("FAIL comb_%0d got=%h exp=%h", i, output1, e[i]);
      end
      #4;
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    en = 1'b1;
    input1 = 8'h12;
    input2 = 8'h34;
    selector = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      total++;
      if (output1_q !== (i[0] ? 8'h34 : 8'h12)) begin
        bad++;
        $display("FAIL reg_q_%0d got=%h exp=%h", i, output1_q,
                 i[0] ? 8'h34 : 8'h12);
      end
      total++;
      if (sel_q !== i[0]) begin
        bad++;
        $display("FAIL reg_sel_%0d got=%b exp=%b", i, sel_q, i[0]);
      end
      @(negedge clk);
      selector = ~selector;
    end
  endtask

  task automatic test_enable_hold();
    @(negedge clk);
    en = 1'b1;
    input1 = 8'h12;
    input2 = 8'h34;
    selector = 1'b1;
    cycle();
    @(negedge clk);
    en = 1'b0;
    input1 = 8'hFF;
    input2 = 8'h00;
    for (int i = 0; i < 3; i++) begin
      selector = i[0];
      cycle();
      total++;
      if (output1_q !== 8'h34 || sel_q !== 1'b1) begin
        bad++;
        $display("FAIL hold_%0d q=%h sel=%b exp=34/1", i, output1_q, sel_q);
      end
      @(negedge clk);
    end
    en = 1'b1;
    selector = 1'b0;
    cycle();
    total++;
    if (output1_q !== 8'hFF || sel_q !== 1'b0) begin
      bad++;
      $display("FAIL hold_release q=%h sel=%b exp=ff/0", output1_q, sel_q);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    en = 1'b1;
    input1 = 8'h12;
    input2 = 8'h34;
    selector = 1'b1;
    cycle();
    #2;
    rst_n = 1'b0;
    m_q = 8'h00;
    m_sel = 1'b0;
    #1;
    total++;
    if (output1_q !== 8'h00 || sel_q !== 1'b0) begin
      bad++;
      $display("FAIL midreset q=%h sel=%b exp=00/0", output1_q, sel_q);
    end
    total++;
    if (output1 !== 8'h34) begin
      bad++;
      $display("FAIL midreset_comb got=%h exp=34", output1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    total++;
    if (output1_q !== 8'h34 || sel_q !== 1'b1) begin
      bad++;
      $display("FAIL reload q=%h sel=%b exp=34/1", output1_q, sel_q);
    end
  endtask

  task automatic test_boundary();
    input1 = 8'hFF;
    input2 = 8'h00;
    for (int i = 0; i < 4; i++) begin
      selector = i[0];
      #1;
      total++;
      if (output1 !== (i[0] ? 8'h00 : 8'hFF)) begin
        bad++;
        $display("FAIL bound_%0d got=%h exp=%h", i, output1,
                 i[0] ? 8'h00 : 8'hFF);
      end
      #4;
    end
  endtask

  task automatic test_random();
    logic [31:0] w1;
    logic [31:0] w2;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      w1 = $urandom;
      w2 = $urandom;
      input1 = w1[7:0];
      input2 = w2[7:0];
      selector = w1[31];
      en = ($urandom_range(0, 3) != 0);
      #1;
      total++;
      if (output1 !== pick(selector, input1, input2)) begin
        bad++;
        $display("FAIL rand_comb_%0d got=%h exp=%h", i, output1,
                 pick(selector, input1, input2));
      end
      cycle();
      total++;
      if (output1_q !== m_q || sel_q !== m_sel) begin
        bad++;
        $display("FAIL rand_reg_%0d q=%h sel=%b exp=%h/%b", i,
                 output1_q, sel_q, m_q, m_sel);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_comb();
    test_registered();
    test_enable_hold();
    test_mid_reset();
    test_boundary();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multiplexor_2to1.md
# multiplexor_2to1

Two-input, WIDTH-bit word selector with a combinational output and a registered copy of that output. `selector` low passes `input1`, `selector` high passes `input2`. The block sits in the 8-bit processor datapath wherever an operand or result source must be chosen. The combinational path serves same-cycle consumers; the registered path serves pipelined consumers.

## Interface
- WIDTH, 8, data width of `input1`, `input2`, `output1` and `output1_q`.
- clk  input  1  single clock; all sequential state updates on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- input1  input  WIDTH  data source 0.
- input2  input  WIDTH  data source 1.
- selector  input  1  0 selects `input1`; 1 selects `input2`.
- en  input  1  load enable for the registered stage.
- output1  output  WIDTH  combinational selected word.
- output1_q  output  WIDTH  registered selected word.
- sel_q  output  1  registered copy of `selector`, captured with `output1_q`.

## Operation
- `output1` = `selector` ? `input2` : `input1`.
  - Purely combinational; no clock or reset dependence.
  - Any X/Z on `selector` drives `output1` to all-X in simulation. No pessimism masking is required.
- Registered stage:
  - On a rising `clk` edge with `rst_n`=1 and `en`=1: `output1_q` ← the `output1` value present before the edge, and `sel_q` ← `selector`.
  - With `en`=0, `output1_q` and `sel_q` hold their values.
- Width rules:
  - No arithmetic is performed.
  - Inputs are used as presented; values wider than WIDTH are truncated by the driver, not by the block.
  - Bits pass through unchanged, in the same bit order (MSB to MSB).
- No internal state exists beyond `output1_q` and `sel_q`.

## Timing
- `output1` latency: zero cycles; it follows input or `selector` changes within the same delta/time step.
- `output1_q` latency: one cycle from the sampling edge.
- Reset:
  - `rst_n` low immediately forces `output1_q`=0 and `sel_q`=0, independent of `clk`.
  - Those values are held while `rst_n` is low.
  - `output1` remains live during reset.
- Reset release:
  - The first rising edge with `rst_n` high and `en`=1 loads normally.
  - Deassertion is expected to be synchronized externally.
- Simultaneous events:
  - An edge coinciding with a `selector` change captures the pre-edge value.
  - Reset asserted on a clock edge wins over `en`.

## Test plan
- Reset: `rst_n`=0 with in1=0xAA, in2=0x55, sel=1, en=1 -> `output1_q`=0x00 and `sel_q`=0 immediately; `output1`=0x55 throughout.
- Combinational select, stepped every 5 time units:
  - in1=0, in2=0, sel=0 -> out=0x00.
  - in1=20, in2=10, sel=1 -> out=10 (0x0A).
  - in1=10, in2=20, sel=0 -> out=10.
  - in1=0x8C, in2=0x1D (908/541 truncated to 8 bits), sel=1 -> out=0x1D.
- Registered path: en=1, in1=0x12, in2=0x34, toggle sel each cycle -> `output1_q` alternates 0x12/0x34 and `sel_q` tracks sel, each one cycle behind.
- Enable hold: load 0x34 with en=1, then en=0 while the inputs change to 0xFF/0x00 -> `output1_q` stays 0x34 until en returns high.
- Mid-operation reset: assert `rst_n` low between clock edges while `output1_q`=0x34 -> `output1_q` is 0 without waiting for an edge; after release, the next enabled edge reloads the selected word.
- All-ones/zero boundary: in1=0xFF, in2=0x00, sweep sel -> out exactly 0xFF/0x00 with no bit leakage from the unselected input.
